// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
package bus_sched_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Destination ID lives in the top ID_W bits of a packet of width sz.
    // The packet is passed zero-extended so one helper serves any width.
    function automatic logic [ID_W-1:0] dest_of(input logic [255:0] packet,
                                                 input int unsigned sz);
        return ID_W'(packet >> (sz - ID_W));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after `last`, wrapping modulo drvrs.
module rr_pick
    import bus_sched_pkg::*;
#(
    parameter int drvrs = 8
) (
    input  logic [drvrs-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    localparam int IW1 = ID_W + 1;

    logic [2*drvrs-1:0] dbl;
    logic [drvrs-1:0]   rot;
    logic [IW1-1:0]     base;
    logic [IW1-1:0]     off;
    logic [IW1-1:0]     sum;

    // Rotate the request vector so bit 0 corresponds to driver last+1.
    always_comb begin
        base = {1'b0, last} + IW1'(1);
        dbl  = {req, req} >> base;
        rot  = dbl[drvrs-1:0];
    end

    // Lowest set bit of the rotated vector, mapped back to a driver index.
    always_comb begin
        valid = |rot;
        off   = '0;
        for (int j = drvrs - 1; j >= 0; j--) begin
            if (rot[j]) off = IW1'(j);
        end
        sum = base + off;
        if (sum >= IW1'(drvrs)) sum = sum - IW1'(drvrs);
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler for the shared packet bus: grants one driver FIFO,
// pops its head packet and pushes it to the addressed receive FIFO(s).
//
//   state | meaning
//   IDLE  | waiting for any pending FIFO; picks next driver after `last`
//   POP   | pop strobe on granted FIFO; head packet captured at end of cycle
//   DRIVE | packet on D_push, push strobes to destination(s) for one cycle
module bus_rr_sched
    import bus_sched_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              drvrs     = 8,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic                            busy,
    output logic [ID_W-1:0]                 grant_id,
    output logic [15:0]                     drop_cnt
);

    localparam int               IW1 = ID_W + 1;
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    state_t               state, state_nxt;
    logic [ID_W-1:0]      last, last_nxt;
    logic [ID_W-1:0]      grant_nxt;
    logic [drvrs-1:0]     pop_nxt, push_nxt;
    logic [pckg_sz-1:0]   dpush_nxt;
    logic [15:0]          drop_nxt;
    logic [pckg_sz-1:0]   pkt_in;
    logic [ID_W-1:0]      dest;
    logic                 dest_valid;
    logic                 pick_valid;
    logic [ID_W-1:0]      pick_idx;

    rr_pick #(
        .drvrs (drvrs)
    ) u_rr_pick (
        .req   (pndng),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Head packet of the granted driver and its destination ID.
    always_comb begin
        pkt_in = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (grant_id == ID_W'(i)) pkt_in = D_pop[i];
        end
        dest       = dest_of(256'(pkt_in), pckg_sz);
        dest_valid = ({1'b0, dest} < IW1'(drvrs));
    end

    // Next-state and next-output decode; strobes default low every cycle.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant_id;
        pop_nxt   = '0;
        push_nxt  = '0;
        dpush_nxt = D_push;
        drop_nxt  = drop_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick_idx;
                    pop_nxt   = ONE << pick_idx;
                    state_nxt = POP;
                end
            end
            POP: begin
                // Transfer is committed here even if pndng drops this cycle.
                last_nxt  = grant_id;
                dpush_nxt = pkt_in;
                state_nxt = DRIVE;
                if (dest == broadcast) begin
                    push_nxt = ~(ONE << grant_id);
                end else if (dest_valid && (dest != grant_id)) begin
                    push_nxt = ONE << dest;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_nxt = drop_cnt + 16'd1;
                end
            end
            DRIVE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Registered outputs, RR pointer and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last     <= ID_W'(drvrs - 1);
            grant_id <= '0;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            drop_cnt <= '0;
        end else begin
            last     <= last_nxt;
            grant_id <= grant_nxt;
            pop      <= pop_nxt;
            push     <= push_nxt;
            D_push   <= dpush_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_rr_sched.sv
// Self-checking bench for bus_rr_sched: transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_bus_rr_sched;

    localparam int N = 8;
    localparam int W = 16;

    logic                clk;
    logic                reset;
    logic [N-1:0]        pndng;
    logic [N-1:0][W-1:0] d_pop;
    logic [N-1:0]        pop;
    logic [N-1:0]        push;
    logic [W-1:0]        D_push;
    logic                busy;
    logic [7:0]          grant_id;
    logic [15:0]         drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int grant_log[$];

    bus_rr_sched #(
        .pckg_sz   (W),
        .drvrs     (N),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .grant_id (grant_id),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_winner(input logic [N-1:0] req, input int last);
        for (int off = 1; off <= N; off++) begin
            if (req[(last + off) % N]) return (last + off) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] exp_push(input logic [W-1:0] pkt, input int src);
        int dest;
        dest = int'(pkt[W-1 -: 8]);
        exp_push = '0;
        if (dest == 255) begin
            exp_push = '1;
            exp_push[src] = 1'b0;
        end else if (dest < N && dest != src) begin
            exp_push[dest] = 1'b1;
        end
    endfunction

    function automatic bit is_drop(input logic [W-1:0] pkt, input int src);
        int dest;
        dest = int'(pkt[W-1 -: 8]);
        return (dest != 255) && !(dest < N && dest != src);
    endfunction

    int          m_phase;
    int          m_last;
    int          m_g;
    logic [N-1:0] e_pop, e_push;
    logic [7:0]  e_grant;
    logic [W-1:0] e_dpush;
    logic [15:0] e_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_last  <= N - 1;
            m_g     <= 0;
            e_pop   <= '0;
            e_push  <= '0;
            e_grant <= '0;
            e_dpush <= '0;
            e_drop  <= '0;
        end else begin
            e_pop  <= '0;
            e_push <= '0;
            case (m_phase)
                0: begin
                    if (pndng != '0) begin
                        m_g     <= rr_winner(pndng, m_last);
                        e_grant <= 8'(rr_winner(pndng, m_last));
                        e_pop   <= N'(1) << rr_winner(pndng, m_last);
                        m_phase <= 1;
                    end
                end
                1: begin
                    m_last  <= m_g;
                    e_dpush <= d_pop[m_g];
                    e_push  <= exp_push(d_pop[m_g], m_g);
                    if (is_drop(d_pop[m_g], m_g) && e_drop != 16'hFFFF) e_drop <= e_drop + 16'd1;
                    m_phase <= 2;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("pop", 32'(pop), 32'(e_pop));
            chk("push", 32'(push), 32'(e_push));
            chk("D_push", 32'(D_push), 32'(e_dpush));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("grant_id", 32'(grant_id), 32'(e_grant));
            chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
        end
    end

    // Record the order in which sources are popped.
    always @(negedge clk) begin
        if (reset && pop != '0) begin
            for (int i = 0; i < N; i++) begin
                if (pop[i]) begin
                    grant_log.push_back(i);
                    break;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send_one(input int src, input logic [W-1:0] pkt,
                            input logic [N-1:0] exp_p, input logic [15:0] exp_drop);
        pndng = N'(1) << src;
        d_pop[src] = pkt;
        @(negedge clk);
        chk("dir_pop", 32'(pop), 32'(N'(1) << src));
        chk("dir_grant", 32'(grant_id), 32'(src));
        chk("dir_push_early", 32'(push), 32'h0);
        pndng = '0;
        @(negedge clk);
        chk("dir_push", 32'(push), 32'(exp_p));
        chk("dir_dpush", 32'(D_push), 32'(pkt));
        chk("dir_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("dir_busy", 32'(busy), 32'h1);
        d_pop[src] = ~pkt;
        @(negedge clk);
        chk("dir_push_1cyc", 32'(push), 32'h0);
        chk("dir_dpush_hold", 32'(D_push), 32'(pkt));
        chk("dir_idle", 32'(busy), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        pndng = '0;
        d_pop = '0;
        repeat (3) @(negedge clk);
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_dpush", 32'(D_push), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // single request, broadcast, invalid/self dest, pending drop in POP
        send_one(2, 16'h05AB, 8'h20, 16'd0);
        send_one(3, 16'hFF12, 8'hF7, 16'd0);
        send_one(1, 16'h0900, 8'h00, 16'd1);
        send_one(1, 16'h0100, 8'h00, 16'd2);
        send_one(4, 16'h0233, 8'h04, 16'd2);

        // reset in the middle of a POP
        pndng = 8'h20;
        d_pop[5] = 16'h0000;
        @(negedge clk);
        chk("mid_pop", 32'(pop), 32'h20);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_pop", 32'(pop), 32'h0);
        chk("mid_rst_push", 32'(push), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_grant", 32'(grant_id), 32'h0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
        pndng = 8'h21;
        d_pop[0] = 16'h0500;
        d_pop[5] = 16'h0300;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        grant_log.delete();
        repeat (6) @(negedge clk);
        pndng = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_log_size", 32'(grant_log.size()), 32'd2);
        chk("mid_first", 32'(grant_log[0]), 32'd0);
        chk("mid_second", 32'(grant_log[1]), 32'd5);

        // fairness with all drivers pending
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        d_pop = '0;
        d_pop[0] = 16'h0100;
        pndng = 8'hFF;
        grant_log.delete();
        repeat (24) @(negedge clk);
        #1;
        chk("fair_pops_24", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk("fair_order", 32'(grant_log[k]), 32'(k));
        repeat (3) @(negedge clk);
        #1;
        chk("fair_pops_27", 32'(grant_log.size()), 32'd9);
        chk("fair_wrap", 32'(grant_log[8]), 32'd0);
        pndng = '0;
        repeat (4) @(negedge clk);

        // randomized traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c == 600 || c == 1100) reset = 1'b0;
            else if (c == 603 || c == 1103) reset = 1'b1;
            if ((c % 200) < 100) pndng = N'($urandom);
            else                 pndng = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) begin
                logic [7:0] dst;
                if ($urandom_range(0, 15) == 0) dst = 8'hFF;
                else                            dst = 8'($urandom_range(0, 11));
                d_pop[i] = {dst, 8'($urandom)};
            end
        end
        @(negedge clk);
        pndng = '0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
